// File: rtl/ara_sim_monitor.sv
// Simulation-control monitor: latches per-channel exit words, produces a sticky
// pass/fail verdict with a cycle-count watchdog, and drives a trace-dump window.
module ara_sim_monitor #(
  parameter int unsigned NrChannels    = 4,
  parameter int unsigned ExitWidth     = 64,
  parameter int unsigned CntWidth      = 32,
  parameter logic [31:0] TimeoutCycles = 32'd1_000_000,
  parameter bit          WaitAll       = 1'b1,
  parameter bit          ReArm         = 1'b0,
  parameter logic [63:0] TrigOn        = 64'h1,
  parameter logic [63:0] TrigOff       = 64'hFFFF_FFFF_FFFF_FFFF,
  localparam int unsigned IdxWidth     = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NrChannels*ExitWidth-1:0]  exit_i,
  input  logic [63:0]                      trigger_i,
  output logic                             done_o,
  output logic                             fail_o,
  output logic                             timeout_o,
  output logic [IdxWidth-1:0]              fail_idx_o,
  output logic [ExitWidth-2:0]             exit_code_o,
  output logic [NrChannels-1:0]            exited_o,
  output logic [CntWidth-1:0]              cycles_o,
  output logic                             dump_en_o,
  output logic                             dump_start_o,
  output logic                             dump_stop_o
);

  localparam logic [CntWidth-1:0] TimeoutLimit = CntWidth'(TimeoutCycles - 32'd1);

  typedef enum logic {RUN, DONE} vstate_t;
  typedef enum logic [1:0] {D_IDLE, D_ON, D_OFF} dstate_t;

  vstate_t                 vstate_reg, vstate_next;
  dstate_t                 dstate_reg, dstate_next;
  logic [NrChannels-1:0]   exited_reg, exited_next;
  logic [NrChannels-1:0]   new_latch, eff_exited, fail_vec;
  logic [ExitWidth-2:0]    code_reg [NrChannels];
  logic [ExitWidth-2:0]    eff_code [NrChannels];
  logic                    fail_reg, fail_next;
  logic                    timeout_reg, timeout_next;
  logic [IdxWidth-1:0]     idx_reg, idx_next;
  logic [ExitWidth-2:0]    xcode_reg, xcode_next;
  logic [CntWidth-1:0]     cycles_reg, cycles_next;
  logic [63:0]             trig_reg;
  logic                    start_reg, start_next;
  logic                    stop_reg, stop_next;

  logic                    any_fail;
  logic [IdxWidth-1:0]     fail_sel;
  logic [ExitWidth-2:0]    sel_code;
  logic                    pass_cond, exit_decide, timeout_hit, done_edge;
  logic                    start_ev, trig_off;

  // Per-channel view that merges already-latched codes with this cycle's new exits
  for (genvar gi = 0; gi < NrChannels; gi++) begin : g_chan
    assign new_latch[gi] = (vstate_reg == RUN) && exit_i[gi*ExitWidth] && !exited_reg[gi];
    assign eff_code[gi]  = exited_reg[gi] ? code_reg[gi]
                                          : exit_i[gi*ExitWidth+1 +: ExitWidth-1];
    assign fail_vec[gi]  = eff_exited[gi] && (eff_code[gi] != '0);

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        code_reg[gi] <= '0;
      end else if (new_latch[gi]) begin
        code_reg[gi] <= exit_i[gi*ExitWidth+1 +: ExitWidth-1];
      end
    end
  end

  assign eff_exited = exited_reg | new_latch;

  // Scan from the top so the lowest failing index is the one left standing
  always_comb begin
    any_fail = 1'b0;
    fail_sel = '0;
    sel_code = '0;
    for (int c = NrChannels - 1; c >= 0; c--) begin
      if (fail_vec[c]) begin
        any_fail = 1'b1;
        fail_sel = IdxWidth'(c);
        sel_code = eff_code[c];
      end
    end
  end

  assign pass_cond   = WaitAll ? (&eff_exited) : (|eff_exited);
  assign exit_decide = (vstate_reg == RUN) && (any_fail || pass_cond);
  assign timeout_hit = (TimeoutCycles != 32'd0) && (vstate_reg == RUN) &&
                       (cycles_reg == TimeoutLimit);
  assign done_edge   = exit_decide || timeout_hit;

  always_comb begin
    vstate_next  = vstate_reg;
    exited_next  = exited_reg;
    fail_next    = fail_reg;
    timeout_next = timeout_reg;
    idx_next     = idx_reg;
    xcode_next   = xcode_reg;
    cycles_next  = cycles_reg;
    if (vstate_reg == RUN) begin
      exited_next = eff_exited;
      if (cycles_reg != '1) begin
        cycles_next = cycles_reg + CntWidth'(1);
      end
      // An exit decided on the watchdog cycle takes precedence over the timeout
      if (exit_decide) begin
        vstate_next = DONE;
        fail_next   = any_fail;
        idx_next    = fail_sel;
        xcode_next  = sel_code;
      end else if (timeout_hit) begin
        vstate_next  = DONE;
        fail_next    = 1'b1;
        timeout_next = 1'b1;
        idx_next     = '0;
        xcode_next   = '1;
      end
    end
  end

  assign start_ev = (trigger_i == TrigOn) && (trig_reg != TrigOn);
  assign trig_off = (trigger_i == TrigOff);

  always_comb begin
    dstate_next = dstate_reg;
    start_next  = 1'b0;
    stop_next   = 1'b0;
    case (dstate_reg)
      D_IDLE: begin
        if (done_edge) begin
          dstate_next = D_OFF;
        end else if (start_ev && (vstate_reg == RUN)) begin
          dstate_next = D_ON;
          start_next  = 1'b1;
        end
      end
      D_ON: begin
        if (trig_off || done_edge) begin
          dstate_next = D_OFF;
          stop_next   = 1'b1;
        end
      end
      D_OFF: begin
        if (ReArm && !done_edge && start_ev && (vstate_reg == RUN)) begin
          dstate_next = D_ON;
          start_next  = 1'b1;
        end
      end
      default: dstate_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vstate_reg  <= RUN;
      dstate_reg  <= D_IDLE;
      exited_reg  <= '0;
      fail_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      idx_reg     <= '0;
      xcode_reg   <= '0;
      cycles_reg  <= '0;
      trig_reg    <= '0;
      start_reg   <= 1'b0;
      stop_reg    <= 1'b0;
    end else begin
      vstate_reg  <= vstate_next;
      dstate_reg  <= dstate_next;
      exited_reg  <= exited_next;
      fail_reg    <= fail_next;
      timeout_reg <= timeout_next;
      idx_reg     <= idx_next;
      xcode_reg   <= xcode_next;
      cycles_reg  <= cycles_next;
      trig_reg    <= trigger_i;
      start_reg   <= start_next;
      stop_reg    <= stop_next;
    end
  end

  assign done_o       = (vstate_reg == DONE);
  assign fail_o       = fail_reg;
  assign timeout_o    = timeout_reg;
  assign fail_idx_o   = idx_reg;
  assign exit_code_o  = xcode_reg;
  assign exited_o     = exited_reg;
  assign cycles_o     = cycles_reg;
  assign dump_en_o    = (dstate_reg == D_ON);
  assign dump_start_o = start_reg;
  assign dump_stop_o  = stop_reg;

endmodule

// File: tb/tb_ara_sim_monitor.sv
// Directed bench for ara_sim_monitor: two instances (WaitAll=1/ReArm=0 and
// WaitAll=0/ReArm=1, both with a 100-cycle watchdog) driven through three runs.
module tb_ara_sim_monitor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] exit_a, exit_b;
  logic [63:0]  trig_a, trig_b;

  logic         done_a, fail_a, tout_a, en_a, start_a, stop_a;
  logic [1:0]   idx_a;
  logic [62:0]  code_a;
  logic [3:0]   exited_a;
  logic [31:0]  cyc_a;

  logic         done_b, fail_b, tout_b, en_b, start_b, stop_b;
  logic [1:0]   idx_b;
  logic [62:0]  code_b;
  logic [3:0]   exited_b;
  logic [31:0]  cyc_b;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  ara_sim_monitor #(
    .NrChannels(4), .ExitWidth(64), .CntWidth(32), .TimeoutCycles(32'd100),
    .WaitAll(1'b1), .ReArm(1'b0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .exit_i(exit_a), .trigger_i(trig_a),
    .done_o(done_a), .fail_o(fail_a), .timeout_o(tout_a), .fail_idx_o(idx_a),
    .exit_code_o(code_a), .exited_o(exited_a), .cycles_o(cyc_a),
    .dump_en_o(en_a), .dump_start_o(start_a), .dump_stop_o(stop_a)
  );

  ara_sim_monitor #(
    .NrChannels(4), .ExitWidth(64), .CntWidth(32), .TimeoutCycles(32'd100),
    .WaitAll(1'b0), .ReArm(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .exit_i(exit_b), .trigger_i(trig_b),
    .done_o(done_b), .fail_o(fail_b), .timeout_o(tout_b), .fail_idx_o(idx_b),
    .exit_code_o(code_b), .exited_o(exited_b), .cycles_o(cyc_b),
    .dump_en_o(en_b), .dump_start_o(start_b), .dump_stop_o(stop_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
    $display("[TB] cycle %0d %s observed=%0h expected=%0h", cyc, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    exit_a = '0; exit_b = '0; trig_a = '0; trig_b = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    exit_a = '0; exit_b = '0; trig_a = '0; trig_b = '0;

    // Run 1: A four-channel pass; B dump window with re-arm, closed by a failing exit
    do_reset();
    chk("rst_done_a", done_a, 0);
    chk("rst_fail_a", fail_a, 0);
    chk("rst_cycles_a", cyc_a, 0);
    chk("rst_exited_a", exited_a, 0);
    chk("rst_code_a", code_a, 0);
    chk("rst_en_b", en_b, 0);
    goto(5);  trig_b = 64'h1;
    tick();
    chk("b_start_pulse", start_b, 1);
    chk("b_en_open", en_b, 1);
    tick();
    chk("b_start_clear", start_b, 0);
    goto(10); exit_a[0*64 +: 64] = 64'h1;
    goto(12); exit_a[1*64 +: 64] = 64'h1; exit_a[2*64 +: 64] = 64'h1;
    tick();
    chk("a_exited_partial", exited_a, 4'h7);
    chk("a_not_done", done_a, 0);
    goto(20);
    chk("b_no_retrigger", start_b, 0);
    chk("b_still_open", en_b, 1);
    exit_a[3*64 +: 64] = 64'h1;
    tick();
    chk("a_pass_done", done_a, 1);
    chk("a_pass_fail", fail_a, 0);
    chk("a_pass_code", code_a, 0);
    chk("a_pass_idx", idx_a, 0);
    chk("a_pass_exited", exited_a, 4'hF);
    chk("a_pass_cycles", cyc_a, 21);
    goto(30);
    chk("a_cycles_frozen", cyc_a, 21);
    trig_b = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("b_stop_pulse", stop_b, 1);
    chk("b_en_closed", en_b, 0);
    tick();
    chk("b_stop_clear", stop_b, 0);
    goto(33); trig_b = 64'h1;
    tick();
    chk("b_rearm_start", start_b, 1);
    chk("b_rearm_en", en_b, 1);
    goto(40); exit_b[0*64 +: 64] = 64'h9;
    tick();
    chk("b_done_close_done", done_b, 1);
    chk("b_done_close_fail", fail_b, 1);
    chk("b_done_close_code", code_b, 4);
    chk("b_done_close_stop", stop_b, 1);
    chk("b_done_close_en", en_b, 0);
    chk("b_done_close_tout", tout_b, 0);
    tick();
    chk("b_done_stop_clear", stop_b, 0);

    // Run 2: A no-rearm window and simultaneous failures; B exit on the watchdog cycle
    do_reset();
    goto(1);  trig_a = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("a_off_in_idle_en", en_a, 0);
    chk("a_off_in_idle_stop", stop_a, 0);
    goto(3);  trig_a = 64'h1;
    tick();
    chk("a_start_pulse", start_a, 1);
    chk("a_en_open", en_a, 1);
    goto(8);  trig_a = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("a_stop_pulse", stop_a, 1);
    chk("a_en_closed", en_a, 0);
    goto(11); trig_a = 64'h1;
    tick();
    chk("a_no_rearm_en", en_a, 0);
    chk("a_no_rearm_start", start_a, 0);
    goto(15); exit_a[1*64 +: 64] = 64'h5; exit_a[2*64 +: 64] = 64'h7;
    tick();
    chk("a_fail_done", done_a, 1);
    chk("a_fail_fail", fail_a, 1);
    chk("a_fail_idx", idx_a, 1);
    chk("a_fail_code", code_a, 2);
    chk("a_fail_exited", exited_a, 4'h6);
    goto(20); exit_a[0*64 +: 64] = 64'h3;
    tick();
    tick();
    chk("a_frozen_exited", exited_a, 4'h6);
    chk("a_frozen_code", code_a, 2);
    chk("a_frozen_idx", idx_a, 1);
    chk("a_frozen_cycles", cyc_a, 16);
    goto(99);
    chk("b_pre_watchdog", done_b, 0);
    exit_b[0*64 +: 64] = 64'h1;
    tick();
    chk("b_race_done", done_b, 1);
    chk("b_race_tout", tout_b, 0);
    chk("b_race_fail", fail_b, 0);
    chk("b_race_code", code_b, 0);

    // Run 3: A reset mid-run with an open window, then the watchdog fires
    do_reset();
    goto(2);  trig_a = 64'h1;
    tick();
    chk("a_mid_en", en_a, 1);
    goto(5);  exit_a[0*64 +: 64] = 64'h1; exit_a[2*64 +: 64] = 64'h1;
    goto(8);
    chk("a_mid_exited", exited_a, 4'h5);
    chk("a_mid_not_done", done_a, 0);
    rst_n = 1'b0; trig_a = '0; exit_a = '0;
    tick();
    chk("a_rst_en", en_a, 0);
    chk("a_rst_stop", stop_a, 0);
    chk("a_rst_exited", exited_a, 0);
    chk("a_rst_cycles", cyc_a, 0);
    tick();
    chk("a_rst_stop2", stop_a, 0);
    rst_n = 1'b1;
    cyc = 0;
    goto(3);
    chk("a_restart_cycles", cyc_a, 3);
    chk("a_restart_en", en_a, 0);
    goto(99);
    chk("a_pre_timeout", done_a, 0);
    tick();
    chk("a_to_done", done_a, 1);
    chk("a_to_fail", fail_a, 1);
    chk("a_to_tout", tout_a, 1);
    chk("a_to_code", code_a, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("a_to_idx", idx_a, 0);
    chk("a_to_cycles", cyc_a, 100);
    tick();
    chk("a_to_cycles_frozen", cyc_a, 100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
